// File: rtl/hvac_sequencer_if.sv
// hvac_sequencer_if: thermostat demand in, plant drives and status out.
// master drives the demand side; slave is the sequencer.
interface hvac_sequencer_if;
  logic       Tick;
  logic [1:0] Mode;
  logic [7:0] CurrentTemp;
  logic [7:0] DesiredTemp;
  logic       Heat;
  logic       Cool;
  logic       Fan;
  logic       Lockout;
  logic       Fault;
  logic [2:0] State;

  modport master (
    output Tick, Mode, CurrentTemp, DesiredTemp,
    input  Heat, Cool, Fan, Lockout, Fault, State
  );

  modport slave (
    input  Tick, Mode, CurrentTemp, DesiredTemp,
    output Heat, Cool, Fan, Lockout, Fault, State
  );
endinterface

// File: rtl/hvac_sequencer.sv
// hvac_sequencer: heat/cool/fan sequencing with hysteresis, min-run, purge, lockout.
// Optional sensor range fault state enabled by `define SENSOR_FAULT_EN.
module hvac_sequencer #(
  parameter int unsigned HYST     = 2,
  parameter int unsigned MIN_ON   = 5,
  parameter int unsigned FAN_POST = 2,
  parameter int unsigned MIN_OFF  = 3,
  parameter int unsigned TMR_W    = 8
) (
  input logic         clk,
  input logic         Reset_n,
  hvac_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HEAT_ON   = 3'd1,
    COOL_ON   = 3'd2,
    FAN_PURGE = 3'd3,
    LOCKOUT   = 3'd4,
    FAULT     = 3'd5
  } state_e;

  localparam logic [TMR_W-1:0] T_ON   = TMR_W'(MIN_ON);
  localparam logic [TMR_W-1:0] T_POST = TMR_W'(FAN_POST);
  localparam logic [TMR_W-1:0] T_OFF  = TMR_W'(MIN_OFF);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d, tmr_run;
  logic             heat_q, cool_q, fan_q, lock_q;

  logic [8:0] cur9, des9, hyst9;
  logic       call_heat, call_cool;
  logic       heat_sat, cool_sat;
  logic       heat_ok, cool_ok;
  logic       tmr_zero;

  assign cur9  = {1'b0, bus.CurrentTemp};
  assign des9  = {1'b0, bus.DesiredTemp};
  assign hyst9 = 9'(HYST);

  assign call_heat = (cur9 + hyst9) < des9;
  assign call_cool = cur9 > (des9 + hyst9);
  assign heat_sat  = cur9 >= des9;
  assign cool_sat  = cur9 <= des9;
  assign heat_ok   = bus.Mode[0];
  assign cool_ok   = bus.Mode[1];
  assign tmr_zero  = (tmr_q == '0);

  // Free-running countdown; any state entry below overrides it with a load.
  assign tmr_run = (bus.Tick && !tmr_zero) ? tmr_q - 1'b1 : tmr_q;

`ifdef SENSOR_FAULT_EN
  logic range_bad;
  logic fault_q;
  assign range_bad = (bus.CurrentTemp > 8'd99) ||
                     (bus.DesiredTemp > 8'd99);
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_run;
    case (state_q)
      IDLE: begin
        if (heat_ok && call_heat) begin
          state_d = HEAT_ON;
          tmr_d   = T_ON;
        end else if (cool_ok && call_cool) begin
          state_d = COOL_ON;
          tmr_d   = T_ON;
        end
      end
      HEAT_ON: begin
        if (tmr_zero && (heat_sat || !heat_ok)) begin
          state_d = FAN_PURGE;
          tmr_d   = T_POST;
        end
      end
      COOL_ON: begin
        if (tmr_zero && (cool_sat || !cool_ok)) begin
          state_d = FAN_PURGE;
          tmr_d   = T_POST;
        end
      end
      FAN_PURGE: begin
        if (tmr_zero) begin
          state_d = LOCKOUT;
          tmr_d   = T_OFF;
        end
      end
      LOCKOUT: begin
        if (tmr_zero) state_d = IDLE;
      end
`ifdef SENSOR_FAULT_EN
      FAULT: begin
        if (!range_bad) begin
          state_d = LOCKOUT;
          tmr_d   = T_OFF;
        end
      end
`endif
      default: begin
        state_d = LOCKOUT;
        tmr_d   = T_OFF;
      end
    endcase
`ifdef SENSOR_FAULT_EN
    if (range_bad) begin
      state_d = FAULT;
      tmr_d   = '0;
    end
`endif
  end

  // Drives are decoded from the next state so they line up with State.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      heat_q  <= 1'b0;
      cool_q  <= 1'b0;
      fan_q   <= 1'b0;
      lock_q  <= 1'b0;
`ifdef SENSOR_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      heat_q  <= (state_d == HEAT_ON);
      cool_q  <= (state_d == COOL_ON);
      fan_q   <= (state_d == HEAT_ON) ||
                 (state_d == COOL_ON) ||
                 (state_d == FAN_PURGE);
      lock_q  <= (state_d == LOCKOUT);
`ifdef SENSOR_FAULT_EN
      fault_q <= (state_d == FAULT);
`endif
    end
  end

  assign bus.Heat    = heat_q;
  assign bus.Cool    = cool_q;
  assign bus.Fan     = fan_q;
  assign bus.Lockout = lock_q;
  assign bus.State   = state_q;
`ifdef SENSOR_FAULT_EN
  assign bus.Fault   = fault_q;
`else
  assign bus.Fault   = 1'b0;
`endif

endmodule
